// File: rtl/stack_sequencer_pkg.sv
// Shared constants for the stack_cpu program sequencer.
//   - OP_*  : stack_cpu opcode nibbles
//   - ST_*  : sequencer FSM state encodings (also visible on dbg_state)
package stack_sequencer_pkg;

  localparam logic [3:0] OP_PUSH = 4'h1;
  localparam logic [3:0] OP_POP  = 4'h2;
  localparam logic [3:0] OP_OUTL = 4'h3;
  localparam logic [3:0] OP_OUTH = 4'h4;
  localparam logic [3:0] OP_SWAP = 4'h5;
  localparam logic [3:0] OP_PUSF = 4'h6;
  localparam logic [3:0] OP_REPL = 4'h7;
  localparam logic [3:0] OP_BINA = 4'h8;
  localparam logic [3:0] OP_MULT = 4'h9;
  localparam logic [3:0] OP_IDIV = 4'hA;
  localparam logic [3:0] OP_CLFL = 4'hB;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_CPU_RESET = 3'd1;
  localparam logic [2:0] ST_FETCH     = 3'd2;
  localparam logic [2:0] ST_EXEC      = 3'd3;
  localparam logic [2:0] ST_DONE      = 3'd4;

endpackage

// File: rtl/stack_sequencer_prog_ram.sv
// Program store for the sequencer: PROG_DEPTH x 4-bit register file.
//   clk            : clock
//   we/waddr/wdata : synchronous write port
//   raddr0/rdata0  : asynchronous read port (opcode, at pc)
//   raddr1/rdata1  : asynchronous read port (operand, at pc+1)
// Contents are deliberately not reset; the sequencer's program length
// gates which entries are ever read.
module stack_prog_ram #(
  parameter int PROG_DEPTH = 16,
  parameter int PTR_W      = 4
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  logic [3:0]       wdata,
  input  logic [PTR_W-1:0] raddr0,
  output logic [3:0]       rdata0,
  input  logic [PTR_W-1:0] raddr1,
  output logic [3:0]       rdata1
);

  logic [3:0] mem [PROG_DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata0 = mem[raddr0];
  assign rdata1 = mem[raddr1];

endmodule

// File: rtl/stack_sequencer.sv
// Program sequencer for stack_cpu. A program of up to PROG_DEPTH nibbles is
// loaded serially while idle, then one run pulse resets the CPU for a cycle
// and replays the program into the CPU's inbits with per-opcode spacing.
//   clk, rst      : clock, synchronous active-high reset
//   load_en       : append load_data to the program (IDLE/DONE only)
//   load_data     : program nibble
//   run           : start execution from address 0 (IDLE/DONE only)
//   cpu_rst       : stack_cpu reset
//   cpu_inbits    : stack_cpu inbits
//   pc            : address of the next nibble to fetch
//   busy          : CPU_RESET, FETCH or EXEC
//   done          : DONE
//   err           : missing-operand fault, sticky until run or rst
//   dbg_state     : current FSM state (ST_* encoding)
//   dbg_prog_len  : number of nibbles loaded (0..PROG_DEPTH)
// Handshake: load_en and run are single-cycle level strobes sampled on the
// rising clock edge; there is no ready, a strobe presented while busy is
// discarded, and run takes priority over load_en in the same cycle.
module stack_sequencer
  import stack_sequencer_pkg::*;
#(
  parameter  int PROG_DEPTH = 16,
  localparam int PTR_W      = $clog2(PROG_DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_en,
  input  logic [3:0]       load_data,
  input  logic             run,
  output logic             cpu_rst,
  output logic [3:0]       cpu_inbits,
  output logic [PTR_W-1:0] pc,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [2:0]       dbg_state,
  output logic [PTR_W:0]   dbg_prog_len
);

  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(PROG_DEPTH);

  // Number of cycles the CPU spends on an opcode after its fetch cycle.
  function automatic logic [1:0] cycles(input logic [3:0] o);
    case (o)
      OP_PUSH, OP_POP, OP_SWAP, OP_PUSF, OP_REPL, OP_BINA: cycles = 2'd2;
      OP_MULT, OP_IDIV:                                    cycles = 2'd3;
      default:                                             cycles = 2'd1;
    endcase
  endfunction

  function automatic logic has_operand(input logic [3:0] o);
    has_operand = (o == OP_PUSH) || (o == OP_PUSF) ||
                  (o == OP_REPL) || (o == OP_BINA);
  endfunction

  logic [2:0]     state;
  logic [PTR_W:0] pc_r;      // one extra bit so pc can reach PROG_DEPTH
  logic [PTR_W:0] wr_ptr;    // doubles as the program length
  logic           err_r;
  logic [3:0]     op;
  logic [3:0]     operand;
  logic [1:0]     cnt;

  logic           idle_like;
  logic           mem_we;
  logic [3:0]     rd0;
  logic [3:0]     rd1;
  logic [PTR_W+1:0] pc_p2;

  assign idle_like = (state == ST_IDLE) || (state == ST_DONE);
  assign mem_we    = idle_like && load_en && !run && (wr_ptr < FULL);
  // Operand lives at pc+1; it exists only if pc+2 <= prog_len.
  assign pc_p2     = {1'b0, pc_r} + (PTR_W+2)'(2);

  stack_prog_ram #(
    .PROG_DEPTH (PROG_DEPTH),
    .PTR_W      (PTR_W)
  ) u_ram (
    .clk    (clk),
    .we     (mem_we),
    .waddr  (wr_ptr[PTR_W-1:0]),
    .wdata  (load_data),
    .raddr0 (pc_r[PTR_W-1:0]),
    .rdata0 (rd0),
    .raddr1 (pc_r[PTR_W-1:0] + PTR_W'(1)),
    .rdata1 (rd1)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      pc_r    <= '0;
      wr_ptr  <= '0;
      err_r   <= 1'b0;
      op      <= 4'h0;
      operand <= 4'h0;
      cnt     <= 2'd0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (run) begin
            state <= ST_CPU_RESET;
            pc_r  <= '0;
            err_r <= 1'b0;
          end else if (load_en) begin
            if (wr_ptr < FULL) wr_ptr <= wr_ptr + 1'b1;
            state <= ST_IDLE;
          end
        end
        ST_CPU_RESET: state <= ST_FETCH;
        ST_FETCH: begin
          if (pc_r == wr_ptr) begin
            state <= ST_DONE;
          end else begin
            op   <= rd0;
            pc_r <= pc_r + 1'b1;
            cnt  <= cycles(rd0) - 2'd1;
            if (rd0 == OP_HALT) begin
              state <= ST_DONE;
            end else if (has_operand(rd0)) begin
              if (pc_p2 > {1'b0, wr_ptr}) begin
                err_r <= 1'b1;
                state <= ST_DONE;
              end else begin
                operand <= rd1;
                pc_r    <= pc_r + 2'd2;
                state   <= ST_EXEC;
              end
            end else begin
              state <= ST_EXEC;
            end
          end
        end
        ST_EXEC: begin
          if (cnt == 2'd0) state <= ST_FETCH;
          else             cnt   <= cnt - 2'd1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // inbits is decoded from state and registers only; during FETCH the
  // addressed nibble is presented so the CPU captures it at the FETCH edge.
  always_comb begin
    cpu_inbits = 4'h0;
    case (state)
      ST_FETCH: cpu_inbits = (pc_r == wr_ptr) ? OP_HALT : rd0;
      ST_EXEC:  cpu_inbits = has_operand(op) ? operand : 4'h0;
      default:  cpu_inbits = 4'h0;
    endcase
  end

  // rst is forwarded directly so the CPU is held in reset on the same cycles.
  assign cpu_rst      = rst || (state == ST_CPU_RESET);
  assign pc           = pc_r[PTR_W-1:0];
  assign busy         = (state == ST_CPU_RESET) || (state == ST_FETCH) ||
                        (state == ST_EXEC);
  assign done         = (state == ST_DONE);
  assign err          = err_r;
  assign dbg_state    = state;
  assign dbg_prog_len = wr_ptr;

endmodule
